// File: rtl/fp_ctrl_pkg.sv
// Shared types and constants for the frame-pointer window controller.
// Holds the controller state encoding, datapath widths and the CALL sum helper.
package fp_ctrl_pkg;

  localparam int FP_W    = 4;
  localparam int SHIFT_W = 3;
  localparam int SUM_W   = FP_W + 1;
  localparam int DEPTH_W = 4;

  localparam int DEF_FP_MAX = 8;
  localparam int DEF_DEPTH  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MOVE  = 2'd1,
    FAULT = 2'd2
  } fp_state_e;

  // One extra bit so an overshoot past the register file is visible rather than wrapping.
  function automatic logic [SUM_W-1:0] callSum(input logic [FP_W-1:0] fp,
                                               input logic [SHIFT_W-1:0] sh);
    return {1'b0, fp} + {{(SUM_W-SHIFT_W){1'b0}}, sh};
  endfunction

endpackage

// File: rtl/shift_stack.sv
// LIFO of per-CALL window shifts with a registered occupancy count.
// The top entry is read combinationally so a RTN can compute its new FP in the same cycle.
module shift_stack
  import fp_ctrl_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int W     = SHIFT_W,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [W-1:0]     i_data,
  output logic [W-1:0]     o_top,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     r_mem [DEPTH];
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] w_wrIdx;
  logic [PTR_W-1:0] w_topIdx;
  logic             w_doPush;
  logic             w_doPop;

  assign w_wrIdx  = PTR_W'(r_count);
  assign w_topIdx = PTR_W'(r_count - CNT_W'(1));
  assign o_full   = (r_count == CNT_W'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign o_count  = r_count;
  assign o_top    = r_mem[w_topIdx];

  assign w_doPush = i_push && !o_full;
  assign w_doPop  = i_pop && !o_empty;

  // Entry storage needs no reset: nothing reads it until the count says it is valid.
  always_ff @(posedge i_clock) begin
    if (w_doPush) begin
      r_mem[w_wrIdx] <= i_data;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (w_doPush) begin
      r_count <= r_count + CNT_W'(1);
    end else if (w_doPop) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/fp_window_ctrl.sv
// Frame-pointer window controller: turns CALL/RTN requests into single-cycle FP moves,
// keeping a stack of CALL shifts so each RTN undoes exactly its matching CALL.
module fp_window_ctrl
  import fp_ctrl_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int FP_MAX = DEF_FP_MAX
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Call_Req,
  input  logic               Rtn_Req,
  input  logic [SHIFT_W-1:0] Shift,
  output logic               Ack,
  output logic               Fault,
  output logic               Busy,
  output logic [FP_W-1:0]    New_FP,
  output logic               FP_move,
  output logic               FP_push_up,
  output logic [FP_W-1:0]    Cur_FP,
  output logic [DEPTH_W-1:0] Depth
);

  localparam int               CNT_W   = $clog2(DEPTH + 1);
  localparam logic [SUM_W-1:0] MAX_SUM = SUM_W'(FP_MAX);

  fp_state_e          r_state;
  fp_state_e          w_nextState;
  logic [FP_W-1:0]    r_curFp;
  logic [FP_W-1:0]    r_newFp;
  logic [FP_W-1:0]    w_nextNewFp;
  logic               r_pushUp;
  logic               w_nextPushUp;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic [SHIFT_W-1:0] w_top;
  logic [CNT_W-1:0]   w_count;
  logic [SUM_W-1:0]   w_sum;
  logic [FP_W-1:0]    w_rtnFp;

  shift_stack #(
    .DEPTH (DEPTH),
    .W     (SHIFT_W),
    .CNT_W (CNT_W)
  ) u_stack (
    .i_clock (Clock),
    .i_reset (Reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (Shift),
    .o_top   (w_top),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign w_sum   = callSum(r_curFp, Shift);
  assign w_rtnFp = r_curFp - {{(FP_W-SHIFT_W){1'b0}}, w_top};

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state  <= IDLE;
      r_curFp  <= '0;
      r_newFp  <= '0;
      r_pushUp <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_newFp  <= w_nextNewFp;
      r_pushUp <= w_nextPushUp;
      if (r_state == MOVE) begin
        r_curFp <= r_newFp;
      end
    end
  end

  // CALL has priority; a faulted request leaves the stack, FP and move registers untouched.
  always_comb begin
    w_nextState  = r_state;
    w_nextNewFp  = r_newFp;
    w_nextPushUp = r_pushUp;
    w_push       = 1'b0;
    w_pop        = 1'b0;
    case (r_state)
      IDLE: begin
        if (Call_Req) begin
          if ((w_sum > MAX_SUM) || w_full) begin
            w_nextState = FAULT;
          end else begin
            w_push       = 1'b1;
            w_nextNewFp  = w_sum[FP_W-1:0];
            w_nextPushUp = 1'b1;
            w_nextState  = MOVE;
          end
        end else if (Rtn_Req) begin
          if (w_empty) begin
            w_nextState = FAULT;
          end else begin
            w_pop        = 1'b1;
            w_nextNewFp  = w_rtnFp;
            w_nextPushUp = 1'b0;
            w_nextState  = MOVE;
          end
        end
      end
      MOVE:    w_nextState = IDLE;
      FAULT:   w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  assign Ack        = (r_state != IDLE);
  assign Busy       = (r_state != IDLE);
  assign FP_move    = (r_state == MOVE);
  assign Fault      = (r_state == FAULT);
  assign New_FP     = r_newFp;
  assign FP_push_up = r_pushUp;
  assign Cur_FP     = r_curFp;
  assign Depth      = DEPTH_W'(w_count);

  // The stack must always hold enough shift to cover a pop without FP underflow.
  assert property (@(posedge Clock) disable iff (Reset) !(w_push && w_pop));
  assert property (@(posedge Clock) disable iff (Reset)
                   w_pop |-> (r_curFp >= {{(FP_W-SHIFT_W){1'b0}}, w_top}));

endmodule

// File: tb/tb_fp_window_ctrl.sv
// Self-checking bench for fp_window_ctrl: directed scenarios plus randomized CALL/RTN
// traffic compared against a queue-based model of the frame pointer and shift stack.
module tb_fp_window_ctrl;

  localparam int M_DEPTH  = 8;
  localparam int M_FP_MAX = 8;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       Call_Req = 1'b0;
  logic       Rtn_Req = 1'b0;
  logic [2:0] Shift = 3'd0;
  logic       Ack;
  logic       Fault;
  logic       Busy;
  logic [3:0] New_FP;
  logic       FP_move;
  logic       FP_push_up;
  logic [3:0] Cur_FP;
  logic [3:0] Depth;

  int errorCount = 0;
  int checkCount = 0;

  int modelFp = 0;
  int modelNewFp = 0;
  int modelPushUp = 0;
  int modelStack[$];

  fp_window_ctrl #(
    .DEPTH  (M_DEPTH),
    .FP_MAX (M_FP_MAX)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Call_Req   (Call_Req),
    .Rtn_Req    (Rtn_Req),
    .Shift      (Shift),
    .Ack        (Ack),
    .Fault      (Fault),
    .Busy       (Busy),
    .New_FP     (New_FP),
    .FP_move    (FP_move),
    .FP_push_up (FP_push_up),
    .Cur_FP     (Cur_FP),
    .Depth      (Depth)
  );

  always #5 Clock = ~Clock;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic clearModel();
    modelFp = 0;
    modelNewFp = 0;
    modelPushUp = 0;
    modelStack.delete();
  endtask

  task automatic doReset();
    Reset = 1'b1;
    Call_Req = 1'b0;
    Rtn_Req = 1'b0;
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    clearModel();
  endtask

  task automatic waitAck(output int cycles);
    cycles = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clock);
      cycles++;
      if (Ack) return;
    end
    checkOutput("ackTimeout", 0, 1);
  endtask

  // Called at the negedge where Ack is visible; decides the outcome from the rules alone.
  task automatic checkTransaction(input bit isCall, input int sh);
    int  oldFp;
    bit  fault;
    int  newFp;
    oldFp = modelFp;
    newFp = 0;
    if (isCall) begin
      newFp = modelFp + sh;
      fault = (newFp > M_FP_MAX) || (modelStack.size() == M_DEPTH);
    end else begin
      fault = (modelStack.size() == 0);
      if (!fault) newFp = modelFp - modelStack[$];
    end
    if (!fault) begin
      if (isCall) modelStack.push_back(sh);
      else void'(modelStack.pop_back());
      modelNewFp = newFp;
      modelPushUp = isCall ? 1 : 0;
      modelFp = newFp;
    end
    checkOutput("ack", Ack, 1);
    checkOutput("busy", Busy, 1);
    checkOutput("fault", Fault, fault ? 1 : 0);
    checkOutput("fpMove", FP_move, fault ? 0 : 1);
    checkOutput("newFp", New_FP, modelNewFp);
    checkOutput("pushUp", FP_push_up, modelPushUp);
    checkOutput("depth", Depth, modelStack.size());
    checkOutput("curFpBeforeCommit", Cur_FP, oldFp);
  endtask

  task automatic applyStimulus(input bit isCall, input bit isRtn, input int sh);
    int cycles;
    Call_Req = isCall;
    Rtn_Req = isRtn;
    Shift = 3'(sh);
    waitAck(cycles);
    checkOutput("ackLatency", cycles, 1);
    checkTransaction(isCall, sh);
    Call_Req = 1'b0;
    Rtn_Req = 1'b0;
    @(negedge Clock);
    checkOutput("curFp", Cur_FP, modelFp);
    checkOutput("idleAck", Ack, 0);
    checkOutput("idleBusy", Busy, 0);
  endtask

  initial begin
    int cycles;
    int r;
    int sh;

    repeat (3) @(negedge Clock);
    Reset = 1'b0;
    clearModel();

    for (int i = 0; i < 10; i++) begin
      @(negedge Clock);
      checkOutput("rstCurFp", Cur_FP, 0);
      checkOutput("rstDepth", Depth, 0);
      checkOutput("rstNewFp", New_FP, 0);
      checkOutput("rstStrobes", {Ack, Fault, Busy, FP_move, FP_push_up}, 0);
    end

    applyStimulus(1, 0, 3);
    applyStimulus(1, 0, 4);
    checkOutput("call34CurFp", Cur_FP, 7);
    checkOutput("call34Depth", Depth, 2);
    applyStimulus(0, 1, 0);
    applyStimulus(0, 1, 0);
    checkOutput("rtnRtnCurFp", Cur_FP, 0);
    applyStimulus(0, 1, 0);
    applyStimulus(1, 0, 3);
    applyStimulus(1, 0, 4);
    applyStimulus(1, 0, 2);
    checkOutput("overCurFp", Cur_FP, 7);
    checkOutput("overDepth", Depth, 2);

    doReset();
    Call_Req = 1'b1;
    Rtn_Req = 1'b1;
    Shift = 3'd0;
    waitAck(cycles);
    checkOutput("bothFirstLatency", cycles, 1);
    checkTransaction(1, 0);
    @(negedge Clock);
    checkOutput("bothGapAck", Ack, 0);
    waitAck(cycles);
    checkOutput("bothSecondLatency", cycles, 1);
    checkTransaction(1, 0);
    Call_Req = 1'b0;
    waitAck(cycles);
    checkOutput("bothRtnLatency", cycles, 2);
    checkTransaction(0, 0);
    Rtn_Req = 1'b0;
    @(negedge Clock);
    checkOutput("bothDepth", Depth, 1);

    doReset();
    applyStimulus(1, 0, 3);
    Call_Req = 1'b1;
    Shift = 3'd5;
    waitAck(cycles);
    checkOutput("rstMoveStrobe", FP_move, 1);
    checkOutput("rstMoveNewFp", New_FP, 8);
    Reset = 1'b1;
    Call_Req = 1'b0;
    @(negedge Clock);
    checkOutput("rstMoveCurFp", Cur_FP, 0);
    checkOutput("rstMoveDepth", Depth, 0);
    checkOutput("rstMoveNewFpClr", New_FP, 0);
    checkOutput("rstMoveStrobes", {Ack, Fault, Busy, FP_move, FP_push_up}, 0);
    Reset = 1'b0;
    clearModel();
    @(negedge Clock);

    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 99);
      sh = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 1) : $urandom_range(0, 7);
      if (r < 55) applyStimulus(1, 0, sh);
      else if (r < 60) applyStimulus(1, 1, sh);
      else applyStimulus(0, 1, sh);
      if ($urandom_range(0, 7) == 0) begin
        @(negedge Clock);
        checkOutput("gapAck", Ack, 0);
        checkOutput("gapCurFp", Cur_FP, modelFp);
      end
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
